// File: rtl/cpu_lr_ctrl.sv
// cpu_lr_ctrl: hardware-loop controller owning the write port of cpu_lr.
// Starts counted loops, decrements the count and issues back-branches at
// loop end, arbitrates software writes to cpu_lr and flags misuse.
//
// Ports:
//   CLK, N_RST            clock, asynchronous active-low reset
//   EN                    CPU advance enable (low = stall)
//   LOOP_START, LOOP_CNT, LOOP_ADDR   decoder loop-open request
//   LOOP_END              decoder loop-close request
//   LR_WR, LR_WDATA       software write request to cpu_lr
//   LR_OUT                current cpu_lr contents
//   LR_LD, LR_DATA        load strobe / data to cpu_lr
//   JMP, JMP_ADDR         back-branch request and target
//   BUSY                  loop active
//   ERR                   sticky protocol error
module cpu_lr_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  N_RST,
    input  logic                  EN,
    input  logic                  LOOP_START,
    input  logic [WIDTH-1:0]      LOOP_CNT,
    input  logic [ADDR_WIDTH-1:0] LOOP_ADDR,
    input  logic                  LOOP_END,
    input  logic                  LR_WR,
    input  logic [WIDTH-1:0]      LR_WDATA,
    input  logic [WIDTH-1:0]      LR_OUT,
    output logic                  LR_LD,
    output logic [WIDTH-1:0]      LR_DATA,
    output logic                  JMP,
    output logic [ADDR_WIDTH-1:0] JMP_ADDR,
    output logic                  BUSY,
    output logic                  ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sa_q, sa_d;
    logic                    err_q, err_d;

    logic                    ctrl_ld;
    logic [WIDTH-1:0]        ctrl_data;
    logic                    jmp;
    logic [ADDR_WIDTH-1:0]   jmp_addr;
    logic                    err_ev;
    logic                    out_en;

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q <= IDLE;
            sa_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        err_d     = err_q;
        ctrl_ld   = 1'b0;
        ctrl_data = '0;
        jmp       = 1'b0;
        jmp_addr  = '0;
        err_ev    = 1'b0;
        if (EN) begin
            unique case (state_q)
                IDLE: begin
                    if (LOOP_START) begin
                        ctrl_ld   = 1'b1;
                        ctrl_data = LOOP_CNT;
                        sa_d      = LOOP_ADDR;
                        state_d   = RUN;
                    end
                    // Loop end with no open loop: ignored.
                    if (LOOP_END) begin
                        err_ev = 1'b1;
                    end
                end
                RUN: begin
                    // No nesting: a second start is dropped.
                    if (LOOP_START) begin
                        err_ev = 1'b1;
                    end
                    if (LOOP_END) begin
                        ctrl_ld = 1'b1;
                        if (LR_OUT > WIDTH'(1)) begin
                            ctrl_data = LR_OUT - WIDTH'(1);
                            jmp       = 1'b1;
                            jmp_addr  = sa_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // Controller owns the port; a colliding software write is lost.
            if (LR_WR && ctrl_ld) begin
                err_ev = 1'b1;
            end
            err_d = err_q | err_ev;
        end
    end

    // Outputs are forced quiet during stall and while reset is held.
    assign out_en   = N_RST & EN;
    assign LR_LD    = out_en & (ctrl_ld | LR_WR);
    assign LR_DATA  = !out_en ? '0 :
                      ctrl_ld ? ctrl_data :
                      LR_WR   ? LR_WDATA  : '0;
    assign JMP      = out_en & jmp;
    assign JMP_ADDR = (out_en && jmp) ? jmp_addr : '0;
    assign BUSY     = (state_q == RUN);
    assign ERR      = err_q;

endmodule

// File: tb/tb_cpu_lr_ctrl.sv
// tb_cpu_lr_ctrl: directed self-checking bench for cpu_lr_ctrl.
// Models cpu_lr as a plain register loaded by LR_LD.
module tb_cpu_lr_ctrl;

    logic       CLK;
    logic       N_RST;
    logic       EN;
    logic       LOOP_START;
    logic [7:0] LOOP_CNT;
    logic [7:0] LOOP_ADDR;
    logic       LOOP_END;
    logic       LR_WR;
    logic [7:0] LR_WDATA;
    logic [7:0] LR_OUT;
    logic       LR_LD;
    logic [7:0] LR_DATA;
    logic       JMP;
    logic [7:0] JMP_ADDR;
    logic       BUSY;
    logic       ERR;

    int checks   = 0;
    int failures = 0;

    logic [7:0] lr = 8'h00;

    cpu_lr_ctrl #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
        .CLK        (CLK),
        .N_RST      (N_RST),
        .EN         (EN),
        .LOOP_START (LOOP_START),
        .LOOP_CNT   (LOOP_CNT),
        .LOOP_ADDR  (LOOP_ADDR),
        .LOOP_END   (LOOP_END),
        .LR_WR      (LR_WR),
        .LR_WDATA   (LR_WDATA),
        .LR_OUT     (LR_OUT),
        .LR_LD      (LR_LD),
        .LR_DATA    (LR_DATA),
        .JMP        (JMP),
        .JMP_ADDR   (JMP_ADDR),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cpu_lr register: loaded only by the controller strobe.
    always @(posedge CLK) begin
        if (LR_LD) lr <= LR_DATA;
    end
    assign LR_OUT = lr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        LOOP_START = 1'b0;
        LOOP_CNT   = 8'h00;
        LOOP_ADDR  = 8'h00;
        LOOP_END   = 1'b0;
        LR_WR      = 1'b0;
        LR_WDATA   = 8'h00;
    endtask

    // Drive at negedge, settle, then checks follow in the caller.
    task automatic nxt();
        @(negedge CLK);
        idle_in();
    endtask

    task automatic edge_();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_in();
        N_RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        N_RST = 1'b1;
    endtask

    initial begin
        EN    = 1'b1;
        N_RST = 1'b0;
        idle_in();
        #12;
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_ld", LR_LD, 0);
        chk("rst_jmp", JMP, 0);
        @(negedge CLK);
        N_RST = 1'b1;

        // Loop of 3 at 0x10
        nxt(); LOOP_START = 1; LOOP_CNT = 3; LOOP_ADDR = 8'h10; #1;
        chk("t1_st_ld", LR_LD, 1);
        chk("t1_st_data", LR_DATA, 3);
        chk("t1_st_jmp", JMP, 0);
        edge_();
        chk("t1_busy", BUSY, 1);
        nxt(); nxt();
        nxt(); LOOP_END = 1; #1;
        chk("t1_e1_jmp", JMP, 1);
        chk("t1_e1_addr", JMP_ADDR, 8'h10);
        chk("t1_e1_data", LR_DATA, 2);
        edge_();
        chk("t1_e1_busy", BUSY, 1);
        nxt(); nxt();
        nxt(); LOOP_END = 1; #1;
        chk("t1_e2_jmp", JMP, 1);
        chk("t1_e2_addr", JMP_ADDR, 8'h10);
        chk("t1_e2_data", LR_DATA, 1);
        edge_();
        nxt(); nxt();
        nxt(); LOOP_END = 1; #1;
        chk("t1_e3_jmp", JMP, 0);
        chk("t1_e3_addr", JMP_ADDR, 0);
        chk("t1_e3_ld", LR_LD, 1);
        chk("t1_e3_data", LR_DATA, 0);
        edge_();
        chk("t1_e3_busy", BUSY, 0);
        chk("t1_err", ERR, 0);

        // Count 0 and count 1
        nxt(); LOOP_START = 1; LOOP_CNT = 0; LOOP_ADDR = 8'h22; #1;
        chk("t2_c0_data", LR_DATA, 0);
        edge_();
        chk("t2_c0_busy", BUSY, 1);
        nxt(); LOOP_END = 1; #1;
        chk("t2_c0_jmp", JMP, 0);
        edge_();
        chk("t2_c0_idle", BUSY, 0);
        nxt(); LOOP_START = 1; LOOP_CNT = 1; LOOP_ADDR = 8'h24; #1;
        chk("t2_c1_data", LR_DATA, 1);
        edge_();
        chk("t2_c1_busy", BUSY, 1);
        nxt(); LOOP_END = 1; #1;
        chk("t2_c1_jmp", JMP, 0);
        chk("t2_c1_data0", LR_DATA, 0);
        edge_();
        chk("t2_c1_idle", BUSY, 0);
        chk("t2_lr", lr, 0);
        chk("t2_err", ERR, 0);

        // Software writes in RUN
        nxt(); LOOP_START = 1; LOOP_CNT = 5; LOOP_ADDR = 8'h20;
        edge_();
        chk("t3_lr5", lr, 5);
        nxt(); LR_WR = 1; LR_WDATA = 8'hA7; #1;
        chk("t3_sw_ld", LR_LD, 1);
        chk("t3_sw_data", LR_DATA, 8'hA7);
        edge_();
        chk("t3_sw_err", ERR, 0);
        nxt(); LR_WR = 1; LR_WDATA = 8'h33; LOOP_END = 1; #1;
        chk("t3_cf_data", LR_DATA, 8'hA6);
        chk("t3_cf_jmp", JMP, 1);
        chk("t3_cf_addr", JMP_ADDR, 8'h20);
        edge_();
        chk("t3_cf_err", ERR, 1);
        chk("t3_cf_busy", BUSY, 1);

        // Nested start ignored
        do_reset();
        #1;
        chk("t4_rst_err", ERR, 0);
        nxt(); LOOP_START = 1; LOOP_CNT = 4; LOOP_ADDR = 8'h30;
        edge_();
        nxt(); LOOP_START = 1; LOOP_CNT = 9; LOOP_ADDR = 8'h40; #1;
        chk("t4_ns_ld", LR_LD, 0);
        chk("t4_ns_jmp", JMP, 0);
        edge_();
        chk("t4_ns_err", ERR, 1);
        chk("t4_ns_lr", lr, 4);
        nxt(); LOOP_END = 1; #1;
        chk("t4_sa_kept", JMP_ADDR, 8'h30);
        chk("t4_dec", LR_DATA, 3);

        // Loop end in IDLE
        do_reset();
        #1;
        chk("t5_rst_err", ERR, 0);
        nxt(); LOOP_END = 1; #1;
        chk("t5_ld", LR_LD, 0);
        chk("t5_jmp", JMP, 0);
        edge_();
        chk("t5_err", ERR, 1);
        chk("t5_busy", BUSY, 0);
        nxt(); nxt(); nxt();
        #1;
        chk("t5_err_held", ERR, 1);

        // Stall
        do_reset();
        nxt(); LOOP_START = 1; LOOP_CNT = 3; LOOP_ADDR = 8'h50;
        edge_();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            idle_in();
            EN = 0; LOOP_END = 1; #1;
            chk("t6_st_jmp", JMP, 0);
            chk("t6_st_ld", LR_LD, 0);
            edge_();
            chk("t6_st_busy", BUSY, 1);
        end
        chk("t6_lr", lr, 3);
        nxt(); EN = 1; LOOP_END = 1; #1;
        chk("t6_jmp", JMP, 1);
        chk("t6_addr", JMP_ADDR, 8'h50);
        chk("t6_data", LR_DATA, 2);
        edge_();
        chk("t6_err", ERR, 0);

        // Async reset mid-loop
        nxt(); LOOP_END = 1; #1;
        chk("t7_pre_jmp", JMP, 1);
        #2;
        N_RST = 0;
        #1;
        chk("t7_jmp", JMP, 0);
        chk("t7_ld", LR_LD, 0);
        chk("t7_busy", BUSY, 0);
        @(negedge CLK);
        idle_in();
        N_RST = 1;
        edge_();
        chk("t7_busy_rel", BUSY, 0);
        chk("t7_err_rel", ERR, 0);
        chk("t7_lr", lr, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
